// File: rtl/iob_cache_requester.sv
// IOb-bus initiator: valid/ready command stream in, cache IOb port out, in-order read responses back.
// Optional rvalid timeout watchdog enabled by defining IOB_CACHE_REQUESTER_TIMEOUT_EN.
module iob_cache_requester #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_W-1:0]     cmd_addr_i,
  input  logic [DATA_W-1:0]     cmd_wdata_i,
  input  logic [DATA_W/8-1:0]   cmd_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic                  iob_avalid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_ready_i,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  input  logic                  err_clr_i,
  output logic                  err_o
);
  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam int PW = $clog2(RSP_DEPTH);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;
  state_t state_r, state_n;

  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [SW-1:0]     wstrb_r;
  logic              is_rd_r;
  logic [CW-1:0]     outstanding_r, fifo_count_r;
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [DATA_W-1:0] mem_r [RSP_DEPTH];
  logic              acc, cmd_fire, credit_ok, rd_acc;
  logic              rv_exp, rv_unexp, push, pop, to_hit, err_r;

  // Reads only issue when a FIFO slot is guaranteed for their data (no rvalid backpressure).
  assign credit_ok = ({1'b0, outstanding_r} + {1'b0, fifo_count_r}) < (CW+1)'(RSP_DEPTH);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_r <= IDLE;
    else       state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    if (cmd_fire)  state_n = PEND;
    else if (acc)  state_n = IDLE;
  end

  always_comb begin
    iob_avalid_o = (state_r == PEND) && (!is_rd_r || credit_ok);
    acc          = iob_avalid_o & iob_ready_i;
    cmd_ready_o  = (state_r == IDLE) | acc;
    cmd_fire     = cmd_valid_i & cmd_ready_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_r  <= '0;
      wdata_r <= '0;
      wstrb_r <= '0;
      is_rd_r <= 1'b0;
    end else if (cmd_fire) begin
      addr_r  <= cmd_addr_i;
      wdata_r <= cmd_wdata_i;
      wstrb_r <= cmd_wstrb_i;
      is_rd_r <= ~|cmd_wstrb_i;
    end
  end

  assign iob_addr_o  = addr_r;
  assign iob_wdata_o = wdata_r;
  assign iob_wstrb_o = wstrb_r;

  assign rd_acc   = acc & is_rd_r;
  assign rv_exp   = iob_rvalid_i & (outstanding_r != '0);
  assign rv_unexp = iob_rvalid_i & (outstanding_r == '0);
  assign push     = rv_exp;
  assign pop      = rsp_valid_o & rsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_r <= '0;
      fifo_count_r  <= '0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
    end else begin
      case ({rd_acc, rv_exp})
        2'b10:   outstanding_r <= outstanding_r + 1'b1;
        2'b01:   outstanding_r <= outstanding_r - 1'b1;
        default: outstanding_r <= outstanding_r;
      endcase
      case ({push, pop})
        2'b10:   fifo_count_r <= fifo_count_r + 1'b1;
        2'b01:   fifo_count_r <= fifo_count_r - 1'b1;
        default: fifo_count_r <= fifo_count_r;
      endcase
      if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_r[wr_ptr_r] <= iob_rdata_i;
  end

  assign rsp_valid_o = (fifo_count_r != '0);
  assign rsp_rdata_o = mem_r[rd_ptr_r];

`ifdef IOB_CACHE_REQUESTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_r;

  // Error fires on the edge where the count reaches TIMEOUT, then the count saturates.
  assign to_hit = (outstanding_r != '0) & ~rv_exp & (to_cnt_r == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || rv_exp || outstanding_r == '0) to_cnt_r <= '0;
    else if (to_cnt_r != TW'(TIMEOUT))          to_cnt_r <= to_cnt_r + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i)                    err_r <= 1'b0;
    else if (rv_unexp || to_hit)  err_r <= 1'b1;
    else if (err_clr_i)           err_r <= 1'b0;
  end

  assign err_o = err_r;
endmodule

// File: tb/tb_iob_cache_requester.sv
// Directed self-checking bench for iob_cache_requester (RSP_DEPTH=4, TIMEOUT=16).
module tb_iob_cache_requester;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic [3:0]  cmd_wstrb_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        iob_avalid_o;
  logic [31:0] iob_addr_o;
  logic [31:0] iob_wdata_o;
  logic [3:0]  iob_wstrb_o;
  logic        iob_ready_i = 1'b0;
  logic        iob_rvalid_i = 1'b0;
  logic [31:0] iob_rdata_i = '0;
  logic        err_clr_i = 1'b0;
  logic        err_o;

  int checks = 0;
  int failures = 0;

  iob_cache_requester #(.ADDR_W(32), .DATA_W(32), .RSP_DEPTH(4), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
    .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
    .iob_rdata_i(iob_rdata_i), .err_clr_i(err_clr_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs;
    cmd_valid_i = 0; cmd_wstrb_i = '0; rsp_ready_i = 0; iob_ready_i = 0;
    iob_rvalid_i = 0; err_clr_i = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_i = 1; tick(); tick(); rst_i = 0; #1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready_o); end
    checks++; if (iob_avalid_o !== 1'b0) begin failures++; $display("FAIL rst_avalid got=%b exp=0", iob_avalid_o); end
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_o); end
    checks++; if ({iob_addr_o, iob_wdata_o, iob_wstrb_o} !== 68'h0) begin failures++; $display("FAIL rst_iob_fields got=%h/%h/%h exp=0", iob_addr_o, iob_wdata_o, iob_wstrb_o); end
  endtask

  task automatic test_write_read;
    do_reset();
    iob_ready_i = 1;
    cmd_valid_i = 1; cmd_addr_i = 32'h40; cmd_wdata_i = 32'hDEADBEEF; cmd_wstrb_i = 4'hF;
    tick(); cmd_valid_i = 0; #1;
    checks++; if ({iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o} !== {1'b1, 32'h40, 32'hDEADBEEF, 4'hF}) begin failures++; $display("FAIL wr_issue got=%b/%h/%h/%h exp=1/40/deadbeef/f", iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o); end
    tick();
    checks++; if ({iob_avalid_o, rsp_valid_o} !== 2'b00) begin failures++; $display("FAIL wr_done got=%b exp=00", {iob_avalid_o, rsp_valid_o}); end
    cmd_valid_i = 1; cmd_wstrb_i = 4'h0;
    tick(); cmd_valid_i = 0; #1;
    checks++; if ({iob_avalid_o, iob_wstrb_o} !== {1'b1, 4'h0}) begin failures++; $display("FAIL rd_issue got=%b/%h exp=1/0", iob_avalid_o, iob_wstrb_o); end
    tick();
    iob_ready_i = 0;
    tick();
    iob_rvalid_i = 1; iob_rdata_i = 32'hDEADBEEF;
    tick(); iob_rvalid_i = 0; #1;
    checks++; if ({rsp_valid_o, rsp_rdata_o} !== {1'b1, 32'hDEADBEEF}) begin failures++; $display("FAIL rd_rsp got=%b/%h exp=1/deadbeef", rsp_valid_o, rsp_rdata_o); end
    rsp_ready_i = 1;
    tick(); rsp_ready_i = 0; #1;
    checks++; if ({rsp_valid_o, err_o} !== 2'b00) begin failures++; $display("FAIL rd_single_rsp got=%b exp=00", {rsp_valid_o, err_o}); end
  endtask

  task automatic test_credit_limit;
    int n_acc = 0;
    int n_cmd = 0;
    logic rv_next = 0;
    logic [31:0] rv_data = '0;
    do_reset();
    iob_ready_i = 1;
    for (int c = 0; c < 12; c++) begin
      cmd_valid_i = (n_cmd < 6); cmd_addr_i = 32'h200 + 32'(n_cmd * 4); cmd_wstrb_i = 4'h0;
      iob_rvalid_i = rv_next; iob_rdata_i = rv_data;
      #1;
      rv_next = 0;
      if (iob_avalid_o && iob_ready_i) begin rv_next = 1; rv_data = 32'h100 + 32'(n_acc); n_acc++; end
      if (cmd_valid_i && cmd_ready_o) n_cmd++;
      tick();
    end
    cmd_valid_i = 0; iob_rvalid_i = 0; #1;
    checks++; if (n_acc !== 4) begin failures++; $display("FAIL credit_acc_count got=%0d exp=4", n_acc); end
    checks++; if ({iob_avalid_o, cmd_ready_o} !== 2'b00) begin failures++; $display("FAIL credit_blocked got=%b exp=00", {iob_avalid_o, cmd_ready_o}); end
    checks++; if ({rsp_valid_o, rsp_rdata_o} !== {1'b1, 32'h100}) begin failures++; $display("FAIL credit_head got=%b/%h exp=1/100", rsp_valid_o, rsp_rdata_o); end
    rsp_ready_i = 1;
    tick(); rsp_ready_i = 0; #1;
    checks++; if ({iob_avalid_o, iob_addr_o} !== {1'b1, 32'h210}) begin failures++; $display("FAIL credit_fifth got=%b/%h exp=1/210", iob_avalid_o, iob_addr_o); end
    checks++; if (rsp_rdata_o !== 32'h101) begin failures++; $display("FAIL credit_order got=%h exp=101", rsp_rdata_o); end
  endtask

  task automatic test_stall_hold;
    do_reset();
    cmd_valid_i = 1; cmd_addr_i = 32'h80; cmd_wdata_i = 32'h12345678; cmd_wstrb_i = 4'h3;
    tick(); cmd_valid_i = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if ({iob_avalid_o, cmd_ready_o, iob_addr_o, iob_wdata_o, iob_wstrb_o} !== {2'b10, 32'h80, 32'h12345678, 4'h3}) begin failures++; $display("FAIL stall_hold[%0d] got=%b%b/%h/%h/%h exp=10/80/12345678/3", c, iob_avalid_o, cmd_ready_o, iob_addr_o, iob_wdata_o, iob_wstrb_o); end
      tick();
    end
    iob_ready_i = 1; cmd_valid_i = 1; cmd_addr_i = 32'h84; cmd_wstrb_i = 4'hF; #1;
    checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%b exp=1", cmd_ready_o); end
    tick(); cmd_valid_i = 0; #1;
    checks++; if ({iob_avalid_o, iob_addr_o, iob_wstrb_o} !== {1'b1, 32'h84, 4'hF}) begin failures++; $display("FAIL back_to_back got=%b/%h/%h exp=1/84/f", iob_avalid_o, iob_addr_o, iob_wstrb_o); end
    tick();
    checks++; if (iob_avalid_o !== 1'b0) begin failures++; $display("FAIL b2b_done got=%b exp=0", iob_avalid_o); end
  endtask

  task automatic test_simultaneous;
    do_reset();
    iob_ready_i = 1; cmd_valid_i = 1; cmd_wstrb_i = 4'h0; cmd_addr_i = 32'h300;
    tick(); cmd_addr_i = 32'h304;
    tick(); cmd_addr_i = 32'h308;
    tick(); cmd_valid_i = 0; iob_ready_i = 0; iob_rvalid_i = 1; iob_rdata_i = 32'hA0A0;
    tick(); iob_ready_i = 1; iob_rdata_i = 32'hB0B0; rsp_ready_i = 1; #1;
    checks++; if ({iob_avalid_o, rsp_valid_o, rsp_rdata_o} !== {2'b11, 32'hA0A0}) begin failures++; $display("FAIL sim_setup got=%b%b/%h exp=11/a0a0", iob_avalid_o, rsp_valid_o, rsp_rdata_o); end
    tick(); iob_ready_i = 0; iob_rvalid_i = 0; rsp_ready_i = 0; #1;
    checks++; if ({rsp_valid_o, rsp_rdata_o} !== {1'b1, 32'hB0B0}) begin failures++; $display("FAIL sim_fifo got=%b/%h exp=1/b0b0", rsp_valid_o, rsp_rdata_o); end
    rsp_ready_i = 1;
    tick(); rsp_ready_i = 0; #1;
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL sim_fifo_count got=%b exp=0", rsp_valid_o); end
    iob_rvalid_i = 1; iob_rdata_i = 32'hC0C0;
    tick(); iob_rvalid_i = 0; #1;
    checks++; if ({err_o, rsp_valid_o, rsp_rdata_o} !== {2'b01, 32'hC0C0}) begin failures++; $display("FAIL sim_outstanding got=%b%b/%h exp=01/c0c0", err_o, rsp_valid_o, rsp_rdata_o); end
    rsp_ready_i = 1;
    tick(); rsp_ready_i = 0; iob_rvalid_i = 1; iob_rdata_i = 32'hDEAD;
    tick(); iob_rvalid_i = 0; #1;
    checks++; if ({err_o, rsp_valid_o} !== 2'b10) begin failures++; $display("FAIL unexp_rvalid got=%b exp=10", {err_o, rsp_valid_o}); end
    err_clr_i = 1;
    tick(); err_clr_i = 0; #1;
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL err_clr got=%b exp=0", err_o); end
    err_clr_i = 1; iob_rvalid_i = 1;
    tick(); err_clr_i = 0; iob_rvalid_i = 0; #1;
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_set_wins got=%b exp=1", err_o); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    iob_ready_i = 1; cmd_valid_i = 1; cmd_wstrb_i = 4'h0; cmd_addr_i = 32'h500;
    tick(); cmd_addr_i = 32'h504;
    tick(); cmd_valid_i = 0;
    tick(); iob_ready_i = 0;
    rst_i = 1;
    tick(); rst_i = 0; #1;
    checks++; if ({cmd_ready_o, iob_avalid_o, rsp_valid_o, err_o, iob_addr_o} !== {4'b1000, 32'h0}) begin failures++; $display("FAIL mid_rst got=%b%b%b%b/%h exp=1000/0", cmd_ready_o, iob_avalid_o, rsp_valid_o, err_o, iob_addr_o); end
    iob_rvalid_i = 1; iob_rdata_i = 32'h5555;
    tick(); iob_rvalid_i = 0; #1;
    checks++; if ({err_o, rsp_valid_o} !== 2'b10) begin failures++; $display("FAIL late_rvalid got=%b exp=10", {err_o, rsp_valid_o}); end
  endtask

  task automatic test_timeout;
    do_reset();
    cmd_valid_i = 1; cmd_wstrb_i = 4'h0; cmd_addr_i = 32'h600;
    tick(); cmd_valid_i = 0; iob_ready_i = 1;
    tick(); iob_ready_i = 0;
`ifdef IOB_CACHE_REQUESTER_TIMEOUT_EN
    for (int c = 0; c < 15; c++) tick();
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b exp=0", err_o); end
    tick();
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL timeout_fire got=%b exp=1", err_o); end
`else
    for (int c = 0; c < 40; c++) tick();
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL no_timeout got=%b exp=0", err_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_credit_limit();
    test_stall_hold();
    test_simultaneous();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
